msi_irq_scheduler: RTL and testbench
====================================

# msi_irq_scheduler

Sequences interrupt delivery into the MSI_Generator request path. Collects up to NUM_SRC user interrupt sources into a pending register and round-robin arbitrates among unmasked pending sources. Issues one MSI request at a time toward the PCIe core's interrupt handshake, mapping each source onto the vector budget granted by config space. Sits between the MSI_Generator AXI4-Lite register block (mask, pending clear, status) and the PCIe core interrupt port.

## Interface
Parameters:
- NUM_SRC, 8: number of interrupt sources, 1..32.
- HOLDOFF, 4: idle cycles enforced after each completed or timed-out request, 0..255.
- ACK_TIMEOUT, 1024: max cycles MSI_REQ is held waiting for MSI_ACK, 2..65535.

Ports:
- ACLK  in  1  clock; single clock domain.
- ARESETN  in  1  reset, asynchronous, active-low.
- IRQ_IN  in  NUM_SRC  source requests, rising-edge sensitive, synchronous to ACLK.
- IRQ_MASK  in  NUM_SRC  1 = source excluded from arbitration; pending still records.
- PEND_CLR  in  NUM_SRC  one-cycle write-1-to-clear of pending bits.
- MSI_ENABLE  in  1  config-space MSI enable; 0 blocks new arbitration.
- MSI_MMENABLE  in  3  allocated vectors = 2^MSI_MMENABLE; values above 5 are treated as 5.
- MSI_REQ  out  1  interrupt request to core.
- MSI_VECTOR  out  5  vector number, valid while MSI_REQ = 1.
- MSI_ACK  in  1  core accepts request (one-cycle pulse).
- PENDING  out  NUM_SRC  pending register, readable by the register block.
- BUSY  out  1  state is not IDLE.
- TIMEOUT_CNT  out  8  saturating count of timed-out requests.

## Operation
- Edge detect: irq_d <= IRQ_IN; rise = IRQ_IN & ~irq_d. irq_d resets to 0, so a source held high through reset release produces one event.
- Pending update each cycle, per bit: set by rise; cleared by PEND_CLR or by ACK of the granted bit. Set wins over both clears when they coincide in the same cycle, so an ack'd source with a coincident rise stays pending.
- eligible = PENDING & ~IRQ_MASK.
- States and transitions:
  - IDLE: go to ARB when MSI_ENABLE = 1 and eligible != 0.
  - ARB: latch grant = first eligible index strictly after last_grant, wrapping modulo NUM_SRC; go to REQ. If eligible became 0 (cleared), return to IDLE.
  - REQ: MSI_REQ = 1 and MSI_VECTOR is constant. On MSI_ACK, clear pending[grant], set last_grant = grant, go to HOLD (or IDLE if HOLDOFF = 0). If no ack arrives after ACK_TIMEOUT cycles, drop the request, keep pending, increment TIMEOUT_CNT (saturating at 255), and set last_grant = grant so other sources get served.
  - HOLD: down-counter loaded with HOLDOFF; go to IDLE when it reaches 0.
- Vector mapping: V = 2^mm; MSI_VECTOR = grant if grant < V, else V-1. Sources above the budget share the last vector.
- Changes to MSI_ENABLE or IRQ_MASK during REQ do not withdraw the request. The core requires the request to be held until ack or timeout.
- ACK outside REQ is ignored. An ack on the same edge as the timeout counts as an ack.

## Timing
- Reset values: MSI_REQ 0, MSI_VECTOR 0, PENDING 0, BUSY 0, TIMEOUT_CNT 0, state IDLE, last_grant NUM_SRC-1 (source 0 wins first).
- All outputs are registered.
- Latency: if IRQ_IN is first sampled high at edge k, PENDING is set after k, ARB after k+1, and MSI_REQ is high after k+2.
- After the ack edge: MSI_REQ is low, and the pending bit is cleared at that same edge.
- Minimum MSI_REQ low gap between requests: HOLDOFF+2 cycles.
- Timeout: drop occurs at the edge ending the ACK_TIMEOUT-th cycle of MSI_REQ high.
- Asynchronous reset mid-REQ drops MSI_REQ immediately. All pending state is lost.

## Structure
- Package msi_sched_pkg holds:
  - the state enum (IDLE, ARB, REQ, HOLD);
  - MSI_VEC_W = 5 and MAX_SRC = 32;
  - function vec_map(grant, mm).
- Sub-module msi_rr_arbiter: combinational round-robin pick of (eligible, last_grant) to (grant, any). This keeps the priority rotation independently testable.

## Test plan
- Single source: IRQ_IN[3] rises, mm = 3, ack 5 cycles after MSI_REQ. Required: MSI_REQ high 2 edges after sampling, MSI_VECTOR = 3, PENDING[3] clears on ack, BUSY low after HOLDOFF+1 further cycles.
- Round-robin: sources 0, 2 and 5 rise together, immediate acks. Required: grant order 0, 2, 5, then a re-rise of 0 and 5 is served in order 5, 0 (after last_grant = 2, wrapping).
- Vector budget: mm = 1, source 6 pending. Required: MSI_VECTOR = 1. With mm = 0: MSI_VECTOR = 0.
- Mask/enable: source 1 pending with IRQ_MASK[1] = 1 gives no request and PENDING[1] = 1. Unmask with MSI_ENABLE = 0: still no request. Set enable: request with vector 1.
- Timeout: ACK_TIMEOUT = 16, never ack. Required: MSI_REQ high exactly 16 cycles, TIMEOUT_CNT = 1, PENDING kept, re-request after HOLDOFF+2 low cycles. 300 timeouts saturate TIMEOUT_CNT at 255.
- Collisions:
  - Ack coincident with a new rise on the same source: pending stays 1 and a second request follows.
  - PEND_CLR coincident with a rise: the bit stays set.
  - ARESETN low mid-REQ: all outputs 0 immediately.

Source files
------------

// File: rtl/msi_sched_pkg.sv
// msi_sched_pkg: shared types, widths and vector mapping for the MSI interrupt scheduler
package msi_sched_pkg;
    localparam int MSI_VEC_W = 5;
    localparam int MAX_SRC = 32;
    typedef logic [$clog2(MAX_SRC)-1:0] src_idx_t;
    typedef enum logic [1:0] {IDLE, ARB, REQ, HOLD} state_t;
    function automatic logic [MSI_VEC_W-1:0] vec_map(input src_idx_t grant, input logic [2:0] mm);
        logic [2:0] m;
        logic [5:0] v;
        m = (mm > 3'd5) ? 3'd5 : mm;
        v = 6'd1 << m;
        return ({1'b0, grant} < v) ? grant : MSI_VEC_W'(v - 6'd1);
    endfunction
endpackage

// File: rtl/msi_rr_arbiter.sv
// msi_rr_arbiter: combinational round-robin pick of the first eligible source after last_grant
module msi_rr_arbiter
    import msi_sched_pkg::*;
#(
    parameter int NUM_SRC = 8
) (
    input  logic [NUM_SRC-1:0] eligible,
    input  src_idx_t           last_grant,
    output src_idx_t           grant,
    output logic               any
);
    src_idx_t lo, hi;
    logic hi_v;
    always_comb begin
        lo = '0;
        hi = '0;
        hi_v = 1'b0;
        // descending scan so the lowest matching index is written last
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) lo = src_idx_t'(i);
            if (eligible[i] && src_idx_t'(i) > last_grant) begin
                hi = src_idx_t'(i);
                hi_v = 1'b1;
            end
        end
        grant = hi_v ? hi : lo;
        any = |eligible;
    end
endmodule

// File: rtl/msi_irq_scheduler.sv
// msi_irq_scheduler: pends edge-triggered sources and issues one round-robin MSI request at a time
module msi_irq_scheduler
    import msi_sched_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int HOLDOFF = 4,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    input  logic [NUM_SRC-1:0]   IRQ_IN,
    input  logic [NUM_SRC-1:0]   IRQ_MASK,
    input  logic [NUM_SRC-1:0]   PEND_CLR,
    input  logic                 MSI_ENABLE,
    input  logic [2:0]           MSI_MMENABLE,
    output logic                 MSI_REQ,
    output logic [MSI_VEC_W-1:0] MSI_VECTOR,
    input  logic                 MSI_ACK,
    output logic [NUM_SRC-1:0]   PENDING,
    output logic                 BUSY,
    output logic [7:0]           TIMEOUT_CNT
);
    localparam logic [7:0] HOLD_LD = 8'(HOLDOFF > 0 ? HOLDOFF - 1 : 0);
    localparam logic [15:0] TO_LAST = 16'(ACK_TIMEOUT - 1);
    localparam src_idx_t LAST_RST = src_idx_t'(NUM_SRC - 1);
    state_t state, state_n;
    logic [NUM_SRC-1:0] irq_d, pending, rise, eligible, ack_clr;
    src_idx_t last_grant, last_n, grant, grant_n, arb_grant;
    logic [MSI_VEC_W-1:0] vec_q, vec_n;
    logic [15:0] wait_cnt, wait_n;
    logic [7:0] hold_cnt, hold_n, tcnt, tcnt_n;
    logic arb_any, req_q, busy_q;
    assign rise = IRQ_IN & ~irq_d;
    assign eligible = pending & ~IRQ_MASK;
    msi_rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
        .eligible(eligible),
        .last_grant(last_grant),
        .grant(arb_grant),
        .any(arb_any)
    );
    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < NUM_SRC; i++) ack_clr[i] = (state == REQ) && MSI_ACK && (grant == src_idx_t'(i));
    end
    always_comb begin
        state_n = state;
        grant_n = grant;
        last_n = last_grant;
        vec_n = vec_q;
        wait_n = wait_cnt;
        hold_n = hold_cnt;
        tcnt_n = tcnt;
        case (state)
            IDLE: state_n = (MSI_ENABLE && arb_any) ? ARB : IDLE;
            ARB: begin
                state_n = arb_any ? REQ : IDLE;
                grant_n = arb_grant;
                vec_n = vec_map(arb_grant, MSI_MMENABLE);
                wait_n = '0;
            end
            REQ: begin
                if (MSI_ACK || wait_cnt == TO_LAST) begin
                    state_n = (HOLDOFF == 0) ? IDLE : HOLD;
                    last_n = grant;
                    hold_n = HOLD_LD;
                    tcnt_n = (MSI_ACK || tcnt == 8'hFF) ? tcnt : tcnt + 8'd1;
                end else begin
                    wait_n = wait_cnt + 16'd1;
                end
            end
            default: begin
                state_n = (hold_cnt == 8'd0) ? IDLE : HOLD;
                hold_n = hold_cnt - 8'd1;
            end
        endcase
    end
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= IDLE;
            irq_d <= '0;
            pending <= '0;
            grant <= '0;
            last_grant <= LAST_RST;
            vec_q <= '0;
            wait_cnt <= '0;
            hold_cnt <= '0;
            tcnt <= '0;
            req_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state <= state_n;
            irq_d <= IRQ_IN;
            pending <= (pending & ~PEND_CLR & ~ack_clr) | rise;
            grant <= grant_n;
            last_grant <= last_n;
            vec_q <= vec_n;
            wait_cnt <= wait_n;
            hold_cnt <= hold_n;
            tcnt <= tcnt_n;
            req_q <= (state_n == REQ);
            busy_q <= (state_n != IDLE);
        end
    end
    assign MSI_REQ = req_q;
    assign MSI_VECTOR = vec_q;
    assign PENDING = pending;
    assign BUSY = busy_q;
    assign TIMEOUT_CNT = tcnt;
endmodule

// File: tb/tb_msi_irq_scheduler.sv
// tb_msi_irq_scheduler: directed self-checking bench for msi_irq_scheduler
module tb_msi_irq_scheduler;
    logic tb_ACLK;
    logic tb_ARESETN;
    logic [7:0] tb_IRQ_IN, tb_IRQ_MASK, tb_PEND_CLR;
    logic tb_MSI_ENABLE;
    logic [2:0] tb_MSI_MMENABLE;
    logic tb_MSI_REQ;
    logic [4:0] tb_MSI_VECTOR;
    logic tb_MSI_ACK;
    logic [7:0] tb_PENDING;
    logic tb_BUSY;
    logic [7:0] tb_TIMEOUT_CNT;
    int checks = 0;
    int errors = 0;

    msi_irq_scheduler #(.NUM_SRC(8), .HOLDOFF(4), .ACK_TIMEOUT(16)) dut (
        .ACLK(tb_ACLK),
        .ARESETN(tb_ARESETN),
        .IRQ_IN(tb_IRQ_IN),
        .IRQ_MASK(tb_IRQ_MASK),
        .PEND_CLR(tb_PEND_CLR),
        .MSI_ENABLE(tb_MSI_ENABLE),
        .MSI_MMENABLE(tb_MSI_MMENABLE),
        .MSI_REQ(tb_MSI_REQ),
        .MSI_VECTOR(tb_MSI_VECTOR),
        .MSI_ACK(tb_MSI_ACK),
        .PENDING(tb_PENDING),
        .BUSY(tb_BUSY),
        .TIMEOUT_CNT(tb_TIMEOUT_CNT)
    );

    initial tb_ACLK = 1'b0;
    always #5 tb_ACLK = ~tb_ACLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge tb_ACLK);
        #1;
    endtask

    task automatic do_reset();
        tb_ARESETN = 1'b0;
        repeat (2) tick();
        tb_ARESETN = 1'b1;
    endtask

    task automatic pulse(input logic [7:0] v);
        tb_IRQ_IN = v;
        tick();
        tb_IRQ_IN = '0;
    endtask

    task automatic wait_req(input int lim);
        int n = 0;
        while (!tb_MSI_REQ && n < lim) begin
            tick();
            n++;
        end
        if (!tb_MSI_REQ) check("req_wait", 32'(tb_MSI_REQ), 1);
    endtask

    task automatic serve(input string tag, input logic [4:0] exp_vec);
        wait_req(60);
        check(tag, 32'(tb_MSI_VECTOR), 32'(exp_vec));
        tb_MSI_ACK = 1'b1;
        tick();
        tb_MSI_ACK = 1'b0;
    endtask

    task automatic count_req_high(input int lim, output int n);
        n = 0;
        while (tb_MSI_REQ && n < lim) begin
            tick();
            n++;
        end
    endtask

    task automatic count_req_low(input int lim, output int n);
        n = 0;
        while (!tb_MSI_REQ && n < lim) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        tb_IRQ_IN = '0;
        tb_IRQ_MASK = '0;
        tb_PEND_CLR = '0;
        tb_MSI_ENABLE = 1'b1;
        tb_MSI_MMENABLE = 3'd3;
        tb_MSI_ACK = 1'b0;
        do_reset();
        check("rst_req", 32'(tb_MSI_REQ), 0);
        check("rst_vec", 32'(tb_MSI_VECTOR), 0);
        check("rst_pend", 32'(tb_PENDING), 0);
        check("rst_busy", 32'(tb_BUSY), 0);
        check("rst_tcnt", 32'(tb_TIMEOUT_CNT), 0);

        // single source latency and holdoff
        pulse(8'h08);
        check("s_pend_k", 32'(tb_PENDING), 32'h08);
        check("s_busy_k", 32'(tb_BUSY), 0);
        tick();
        check("s_busy_k1", 32'(tb_BUSY), 1);
        check("s_req_k1", 32'(tb_MSI_REQ), 0);
        tick();
        check("s_req_k2", 32'(tb_MSI_REQ), 1);
        check("s_vec", 32'(tb_MSI_VECTOR), 3);
        repeat (4) tick();
        check("s_req_hold", 32'(tb_MSI_REQ), 1);
        tb_MSI_ACK = 1'b1;
        tick();
        tb_MSI_ACK = 1'b0;
        check("s_req_ack", 32'(tb_MSI_REQ), 0);
        check("s_pend_ack", 32'(tb_PENDING), 0);
        check("s_busy_hold", 32'(tb_BUSY), 1);
        repeat (3) tick();
        check("s_busy_a3", 32'(tb_BUSY), 1);
        tick();
        check("s_busy_a4", 32'(tb_BUSY), 0);

        // round robin from reset, then wrap after last_grant = 2
        do_reset();
        pulse(8'h25);
        serve("rr_0", 5'd0);
        serve("rr_2", 5'd2);
        pulse(8'h21);
        check("rr_pend", 32'(tb_PENDING), 32'h21);
        serve("rr_5", 5'd5);
        serve("rr_0b", 5'd0);
        check("rr_empty", 32'(tb_PENDING), 0);

        // vector budget
        tb_MSI_MMENABLE = 3'd1;
        pulse(8'h40);
        serve("vb_mm1", 5'd1);
        tb_MSI_MMENABLE = 3'd0;
        pulse(8'h40);
        serve("vb_mm0", 5'd0);
        tb_MSI_MMENABLE = 3'd7;
        pulse(8'h40);
        serve("vb_mm7", 5'd6);
        check("vb_pend", 32'(tb_PENDING), 0);
        tb_MSI_MMENABLE = 3'd3;

        // mask and enable gating
        tb_IRQ_MASK = 8'h02;
        pulse(8'h02);
        n = 0;
        repeat (12) begin
            tick();
            if (tb_MSI_REQ) n++;
        end
        check("mk_noreq", 32'(n), 0);
        check("mk_pend", 32'(tb_PENDING), 32'h02);
        check("mk_busy", 32'(tb_BUSY), 0);
        tb_MSI_ENABLE = 1'b0;
        tb_IRQ_MASK = '0;
        n = 0;
        repeat (12) begin
            tick();
            if (tb_MSI_REQ) n++;
        end
        check("en_noreq", 32'(n), 0);
        tb_MSI_ENABLE = 1'b1;
        serve("en_vec", 5'd1);

        // timeout behaviour and saturation
        do_reset();
        pulse(8'h10);
        wait_req(20);
        count_req_high(100, n);
        check("to_high", 32'(n), 16);
        check("to_cnt1", 32'(tb_TIMEOUT_CNT), 1);
        check("to_pend", 32'(tb_PENDING), 32'h10);
        count_req_low(100, n);
        check("to_gap", 32'(n), 6);
        check("to_vec", 32'(tb_MSI_VECTOR), 4);
        repeat (300 * 22) tick();
        check("to_sat", 32'(tb_TIMEOUT_CNT), 255);
        tb_PEND_CLR = 8'h10;
        tick();
        tb_PEND_CLR = '0;
        repeat (40) tick();
        check("to_clr_pend", 32'(tb_PENDING), 0);
        check("to_clr_busy", 32'(tb_BUSY), 0);

        // ack coincident with a re-rise of the granted source
        do_reset();
        pulse(8'h04);
        wait_req(20);
        tb_MSI_ACK = 1'b1;
        tb_IRQ_IN = 8'h04;
        tick();
        tb_MSI_ACK = 1'b0;
        tb_IRQ_IN = '0;
        check("co_ack_pend", 32'(tb_PENDING), 32'h04);
        check("co_ack_req", 32'(tb_MSI_REQ), 0);
        serve("co_second", 5'd2);
        check("co_second_pend", 32'(tb_PENDING), 0);

        // PEND_CLR coincident with a rise
        tb_MSI_ENABLE = 1'b0;
        repeat (8) tick();
        tb_IRQ_IN = 8'h80;
        tb_PEND_CLR = 8'h80;
        tick();
        tb_IRQ_IN = '0;
        check("co_clr_rise", 32'(tb_PENDING), 32'h80);
        tick();
        check("co_clr_hold", 32'(tb_PENDING), 32'h00);
        tb_PEND_CLR = '0;
        tb_MSI_ENABLE = 1'b1;

        // asynchronous reset in the middle of a request
        pulse(8'h08);
        wait_req(20);
        check("ar_pre_vec", 32'(tb_MSI_VECTOR), 3);
        tb_ARESETN = 1'b0;
        #1;
        check("ar_req", 32'(tb_MSI_REQ), 0);
        check("ar_vec", 32'(tb_MSI_VECTOR), 0);
        check("ar_pend", 32'(tb_PENDING), 0);
        check("ar_busy", 32'(tb_BUSY), 0);
        tick();
        tb_ARESETN = 1'b1;
        repeat (5) tick();
        check("ar_after", 32'(tb_MSI_REQ), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
